lab2_proc_mem_port_arbiter: RTL and testbench

- Shares one 4B memory request/response port between two requesters: port 0 = data (dmem), port 1 = instruction (imem).
- Sits between the processor's bypass queues and a single-ported memory or cache.
- Rewrites each request's opaque field with an internal tag.
- Uses that tag to route responses back to the issuing requester, restoring the original opaque. Out-of-order responses are therefore legal.

---
 rtl/lab2_proc_mem_port_arbiter_pkg.sv | 27 ++
 rtl/lab2_proc_tag_alloc.sv | 45 ++++
 rtl/lab2_proc_mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_lab2_proc_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_mem_port_arbiter_pkg.sv
// Shared memory message types and port ids for the proc/mem port arbiter.
// Request/response layouts follow the 4-byte memory message format.
package lab2_proc_mem_port_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;

    localparam logic DATA = 1'b0;
    localparam logic INST = 1'b1;

endpackage

// File: rtl/lab2_proc_tag_alloc.sv
// Tag allocator: valid bitmask, lowest-free-tag encoder and outstanding count.
// Latency: free_tag/no_free combinational; alloc/free take effect at the next edge.
// Backpressure: none internally; caller must not alloc when no_free nor free an invalid tag.
module lab2_proc_tag_alloc #(
    parameter int p_num_tags  = 4,
    parameter int p_tag_nbits = $clog2(p_num_tags)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_en,
    input  logic                   free_en,
    input  logic [p_tag_nbits-1:0] free_idx,
    output logic [p_num_tags-1:0]  valid,
    output logic [p_tag_nbits-1:0] free_tag,
    output logic                   no_free,
    output logic [p_tag_nbits:0]   count
);

    logic [p_num_tags-1:0] alloc_bit;
    logic [p_num_tags-1:0] free_bit;

    // Descending scan so the lowest invalid index wins.
    always_comb begin
        free_tag = '0;
        for (int i = p_num_tags - 1; i >= 0; i--) begin
            if (!valid[i]) free_tag = p_tag_nbits'(i);
        end
    end

    assign no_free   = &valid;
    assign alloc_bit = p_num_tags'(alloc_en) << free_tag;
    assign free_bit  = p_num_tags'(free_en) << free_idx;

    // A freed tag only becomes visible to the encoder after this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= (valid | alloc_bit) & ~free_bit;
            count <= count + {{p_tag_nbits{1'b0}}, alloc_en} - {{p_tag_nbits{1'b0}}, free_en};
        end
    end

endmodule

// File: rtl/lab2_proc_mem_port_arbiter.sv
// Shares one memory port between dmem (port 0) and imem (port 1) with tagged, reorderable responses.
// Latency: zero-cycle combinational request and response paths; tag state updates at the edge.
// Backpressure: requests stall when all tags are in use or memory is not ready; stray responses are sunk.
// Optional perf counters when LAB2_PROC_MEM_ARB_PERF_EN is defined.
module lab2_proc_mem_port_arbiter
    import lab2_proc_mem_port_arbiter_pkg::*;
#(
    parameter int p_num_tags  = 4,
    parameter int p_tag_nbits = $clog2(p_num_tags)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  mem_req_4B_t          req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,
    output mem_resp_4B_t         resp0_msg,
    output logic                 resp0_val,
    input  logic                 resp0_rdy,
    input  mem_req_4B_t          req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,
    output mem_resp_4B_t         resp1_msg,
    output logic                 resp1_val,
    input  logic                 resp1_rdy,
    output mem_req_4B_t          memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    input  mem_resp_4B_t         memresp_msg,
    input  logic                 memresp_val,
    output logic                 memresp_rdy,
    output logic [p_tag_nbits:0] num_outstanding
`ifdef LAB2_PROC_MEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_full_stall
`endif
);

    logic                   rr_ptr;
    logic                   grant;
    logic                   any_val;
    logic                   no_free;
    logic                   req_fire;
    logic                   resp_fire;
    logic                   resp_hit;
    logic                   resp_owner;
    logic [p_tag_nbits-1:0] free_tag;
    logic [p_tag_nbits-1:0] resp_tag;
    logic [p_num_tags-1:0]  tag_valid;
    logic [p_num_tags-1:0]  owner_q;
    logic [7:0]             opaque_q [p_num_tags];
    mem_req_4B_t            grant_msg;
    mem_resp_4B_t           resp_msg;

    lab2_proc_tag_alloc #(
        .p_num_tags  (p_num_tags),
        .p_tag_nbits (p_tag_nbits)
    ) u_tag_alloc (
        .clk      (clk),
        .reset    (reset),
        .alloc_en (req_fire),
        .free_en  (resp_fire),
        .free_idx (resp_tag),
        .valid    (tag_valid),
        .free_tag (free_tag),
        .no_free  (no_free),
        .count    (num_outstanding)
    );

    // Grant is stable while both requests are held, since rr_ptr only moves on a fire.
    assign any_val   = req0_val | req1_val;
    assign grant     = (req0_val & req1_val) ? rr_ptr : req1_val;
    assign grant_msg = grant ? req1_msg : req0_msg;

    always_comb begin
        memreq_msg        = grant_msg;
        memreq_msg.opaque = 8'(free_tag);
    end

    assign memreq_val = reset & any_val & ~no_free;
    assign req0_rdy   = reset & (grant == DATA) & memreq_rdy & ~no_free;
    assign req1_rdy   = reset & (grant == INST) & memreq_rdy & ~no_free;
    assign req_fire   = memreq_val & memreq_rdy;

    assign resp_tag   = memresp_msg.opaque[p_tag_nbits-1:0];
    assign resp_hit   = tag_valid[resp_tag];
    assign resp_owner = owner_q[resp_tag];

    always_comb begin
        resp_msg        = memresp_msg;
        resp_msg.opaque = opaque_q[resp_tag];
    end

    assign resp0_msg   = resp_msg;
    assign resp1_msg   = resp_msg;
    assign resp0_val   = memresp_val & resp_hit & (resp_owner == DATA);
    assign resp1_val   = memresp_val & resp_hit & (resp_owner == INST);
    assign memresp_rdy = reset & (resp_hit ? (resp_owner ? resp1_rdy : resp0_rdy) : 1'b1);
    assign resp_fire   = memresp_val & memresp_rdy & resp_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (req_fire) begin
            rr_ptr <= ~grant;
        end
    end

    // Owner/opaque payload is only meaningful under a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            owner_q[free_tag]  <= grant;
            opaque_q[free_tag] <= grant_msg.opaque;
        end
    end

`ifdef LAB2_PROC_MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grant0     <= '0;
            perf_grant1     <= '0;
            perf_full_stall <= '0;
        end else begin
            if (req_fire && grant == DATA) perf_grant0 <= perf_grant0 + 32'd1;
            if (req_fire && grant == INST) perf_grant1 <= perf_grant1 + 32'd1;
            if (any_val && no_free)        perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lab2_proc_mem_port_arbiter.sv
// Randomized scoreboard bench for lab2_proc_mem_port_arbiter with a behavioural tag/fairness model.
// Inputs change 1ns after posedge; the model and response monitor sample on the negedge.
`timescale 1ns/1ps
module tb_lab2_proc_mem_port_arbiter;
    import lab2_proc_mem_port_arbiter_pkg::*;

    localparam int NT = 4;
    localparam int TB = 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    mem_req_4B_t  req0_msg, req1_msg, memreq_msg;
    mem_resp_4B_t resp0_msg, resp1_msg, memresp_msg;
    logic         req0_val, req0_rdy, req1_val, req1_rdy;
    logic         resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [TB:0]  num_outstanding;

    lab2_proc_mem_port_arbiter #(.p_num_tags(NT)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_msg        (req0_msg),
        .req0_val        (req0_val),
        .req0_rdy        (req0_rdy),
        .resp0_msg       (resp0_msg),
        .resp0_val       (resp0_val),
        .resp0_rdy       (resp0_rdy),
        .req1_msg        (req1_msg),
        .req1_val        (req1_val),
        .req1_rdy        (req1_rdy),
        .resp1_msg       (resp1_msg),
        .resp1_val       (resp1_val),
        .resp1_rdy       (resp1_rdy),
        .memreq_msg      (memreq_msg),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memresp_msg     (memresp_msg),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .num_outstanding (num_outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requesters, memory knobs and the reference model state.
    bit           hold [2];
    mem_req_4B_t  pend [2];
    int           quota = 0;
    int           pv [2];
    int           p_mrdy = 100, p_rrdy = 100, p_resp = 0, p_stray = 0;
    bit           out_v [NT];
    bit           out_port [NT];
    mem_req_4B_t  out_req [NT];
    bit           prefer = 1'b0;
    int           n_out = 0, alloc_cnt = 0, last_alloc = -1;
    int           gcnt [2];
    bit           pres = 1'b0, pres_stray = 1'b0, stray_now = 1'b0;
    int           pres_tag = 0;
    int           order_q [$];
    mem_resp_4B_t exp_q0 [$];
    mem_resp_4B_t exp_q1 [$];

    function automatic mem_resp_4B_t mem_reply(input mem_req_4B_t r, input int tag);
        mem_resp_4B_t m;
        m.msg_type = r.msg_type;
        m.opaque   = 8'(tag);
        m.test     = 2'd0;
        m.len      = r.len;
        m.data     = (r.msg_type == MEM_READ) ? ~r.addr : 32'd0;
        return m;
    endfunction

    task automatic drive();
        int           cand [$];
        mem_resp_4B_t m;
        bit           newp;
        for (int p = 0; p < 2; p++) begin
            if (!hold[p] && quota > 0 && $urandom_range(99) < pv[p]) begin
                hold[p] = 1'b1;
                quota--;
                pend[p].msg_type = $urandom_range(1) ? MEM_WRITE : MEM_READ;
                pend[p].opaque   = 8'($urandom);
                pend[p].addr     = $urandom & 32'hFFFF_FFFC;
                pend[p].len      = 2'd0;
                pend[p].data     = $urandom;
            end
        end
        req0_val   = hold[0];
        req0_msg   = pend[0];
        req1_val   = hold[1];
        req1_msg   = pend[1];
        memreq_rdy = ($urandom_range(99) < p_mrdy);
        resp0_rdy  = ($urandom_range(99) < p_rrdy);
        resp1_rdy  = ($urandom_range(99) < p_rrdy);
        newp = 1'b0;
        if (!pres) begin
            if (stray_now || $urandom_range(99) < p_stray) begin
                for (int t = 0; t < NT; t++) if (!out_v[t]) cand.push_back(t);
                if (cand.size() > 0) begin
                    pres_tag   = cand[$urandom_range(cand.size() - 1)];
                    pres = 1'b1; pres_stray = 1'b1; stray_now = 1'b0;
                    memresp_msg          = mem_reply(pend[0], pres_tag);
                    memresp_msg.opaque   = {6'($urandom), 2'(pres_tag)};
                end
                cand.delete();
            end
            if (!pres && order_q.size() > 0) begin
                pres_tag = order_q.pop_front();
                pres = 1'b1; pres_stray = 1'b0; newp = 1'b1;
            end else if (!pres && $urandom_range(99) < p_resp) begin
                for (int t = 0; t < NT; t++) if (out_v[t]) cand.push_back(t);
                if (cand.size() > 0) begin
                    pres_tag = cand[$urandom_range(cand.size() - 1)];
                    pres = 1'b1; pres_stray = 1'b0; newp = 1'b1;
                end
            end
        end
        if (newp) begin
            m           = mem_reply(out_req[pres_tag], pres_tag);
            memresp_msg = m;
            m.opaque    = out_req[pres_tag].opaque;
            if (out_port[pres_tag]) exp_q1.push_back(m);
            else                    exp_q0.push_back(m);
        end
        memresp_val = pres;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Reference model: lowest free tag, round-robin on contention, owner-routed responses.
    always @(negedge clk) begin : model
        bit          v0, v1, g, full, mv, mfire, orv;
        int          ft;
        mem_req_4B_t e;
        if (reset) begin
            v0   = req0_val;
            v1   = req1_val;
            full = (n_out == NT);
            g    = (v0 && v1) ? prefer : v1;
            mv   = (v0 || v1) && !full;
            chk("num_outstanding", num_outstanding, n_out);
            chk("memreq_val", memreq_val, mv);
            chk("req0_rdy", req0_rdy, (g == 1'b0) && memreq_rdy && !full);
            chk("req1_rdy", req1_rdy, (g == 1'b1) && memreq_rdy && !full);
            mfire = mv && memreq_rdy;
            ft = 0;
            for (int t = NT - 1; t >= 0; t--) if (!out_v[t]) ft = t;
            if (mfire) begin
                e = pend[g];
                e.opaque = 8'(ft);
                chk("memreq_msg", memreq_msg, e);
                out_port[ft] = g;
                out_req[ft]  = pend[g];
                hold[g]      = 1'b0;
                prefer       = !g;
                gcnt[g]++;
                alloc_cnt++;
                last_alloc   = ft;
            end
            if (pres && pres_stray) begin
                chk("stray_memresp_rdy", memresp_rdy, 1'b1);
                chk("stray_resp0_val", resp0_val, 1'b0);
                chk("stray_resp1_val", resp1_val, 1'b0);
                if (memresp_rdy) pres = 1'b0;
            end else if (pres) begin
                orv = out_port[pres_tag] ? resp1_rdy : resp0_rdy;
                chk("owner_resp_val", out_port[pres_tag] ? resp1_val : resp0_val, 1'b1);
                chk("other_resp_val", out_port[pres_tag] ? resp0_val : resp1_val, 1'b0);
                chk("memresp_rdy", memresp_rdy, orv);
                if (memresp_rdy) begin
                    out_v[pres_tag] = 1'b0;
                    pres = 1'b0;
                end
            end else begin
                chk("idle_resp0_val", resp0_val, 1'b0);
                chk("idle_resp1_val", resp1_val, 1'b0);
            end
            if (mfire) out_v[ft] = 1'b1;
            n_out = 0;
            for (int t = 0; t < NT; t++) n_out += int'(out_v[t]);
        end
    end

    // Response monitor: pops the port scoreboard on every response handshake.
    always @(negedge clk) begin : monitor
        if (reset && resp0_val && resp0_rdy) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp0_unexpected: got opaque %0h expected no response", resp0_msg.opaque);
            end else chk("resp0_msg", resp0_msg, exp_q0.pop_front());
        end
        if (reset && resp1_val && resp1_rdy) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp1_unexpected: got opaque %0h expected no response", resp1_msg.opaque);
            end else chk("resp1_msg", resp1_msg, exp_q1.pop_front());
        end
    end

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_memreq_val"}, memreq_val, 1'b0);
        chk({tag, "_req0_rdy"}, req0_rdy, 1'b0);
        chk({tag, "_req1_rdy"}, req1_rdy, 1'b0);
        chk({tag, "_memresp_rdy"}, memresp_rdy, 1'b0);
        chk({tag, "_resp0_val"}, resp0_val, 1'b0);
        chk({tag, "_resp1_val"}, resp1_val, 1'b0);
        chk({tag, "_num_outstanding"}, num_outstanding, 0);
    endtask

    task automatic do_reset_mid();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all_quiet("midrst");
        for (int t = 0; t < NT; t++) out_v[t] = 1'b0;
        n_out = 0; prefer = 1'b0; pres = 1'b0;
        exp_q0.delete(); exp_q1.delete(); order_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        stray_now = 1'b1;
        drive();
    endtask

    task automatic drain();
        quota = 0; p_resp = 100; p_rrdy = 100; p_mrdy = 100; p_stray = 0;
        for (int i = 0; i < 200 && (n_out != 0 || pres || hold[0] || hold[1]); i++) step();
        settle();
        chk("drain_num_outstanding", num_outstanding, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int a0;
        pv = '{0, 0}; gcnt = '{0, 0};
        hold = '{1'b0, 1'b0};
        pend[0] = '0; pend[1] = '0;
        for (int t = 0; t < NT; t++) begin out_v[t] = 1'b0; out_port[t] = 1'b0; out_req[t] = '0; end
        req0_val = 1'b0; req1_val = 1'b0; req0_msg = '0; req1_msg = '0;
        memreq_rdy = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        memresp_val = 1'b0; memresp_msg = '0;
        #1 reset = 1'b0;
        #2;
        chk_all_quiet("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Single dmem read: tag 0 outbound, original opaque restored on resp0.
        pend[0] = '{msg_type: MEM_READ, opaque: 8'h5A, addr: 32'h100, len: 2'd0, data: 32'd0};
        hold[0] = 1'b1;
        step(); settle();
        chk("t1_memreq_opaque", memreq_msg.opaque, 8'h00);
        chk("t1_memreq_addr", memreq_msg.addr, 32'h100);
        order_q.push_back(0);
        step(); settle();
        chk("t1_resp0_val", resp0_val, 1'b1);
        chk("t1_resp0_opaque", resp0_msg.opaque, 8'h5A);
        chk("t1_resp1_val", resp1_val, 1'b0);
        drain();

        // Both ports always requesting: fair split of 8 grants.
        gcnt = '{0, 0}; quota = 8; pv = '{100, 100}; p_resp = 100;
        for (int i = 0; i < 60 && (gcnt[0] + gcnt[1]) < 8; i++) step();
        chk("t2_grants_port0", gcnt[0], 4);
        chk("t2_grants_port1", gcnt[1], 4);
        drain();

        // Fill all tags with one extra request held back.
        quota = 5; pv = '{100, 100}; p_resp = 0;
        repeat (8) step();
        settle();
        chk("t3_full_count", num_outstanding, NT);
        chk("t3_full_memreq_val", memreq_val, 1'b0);
        chk("t3_full_req0_rdy", req0_rdy, 1'b0);
        chk("t3_full_req1_rdy", req1_rdy, 1'b0);

        // Freeing tag 2 while full: request waits a cycle, then reuses tag 2.
        a0 = alloc_cnt;
        order_q.push_back(2);
        step(); settle();
        chk("t4_stall_alloc", alloc_cnt, a0);
        step(); settle();
        chk("t4_realloc_count", alloc_cnt, a0 + 1);
        chk("t4_realloc_tag", last_alloc, 2);

        // Out-of-order returns drain the table.
        order_q = '{3, 0, 2, 1};
        repeat (6) step();
        settle();
        chk("t5_ooo_drained", num_outstanding, 0);

        // Stray response is sunk even with both response ports stalled.
        p_rrdy = 0; stray_now = 1'b1;
        step(); settle();
        chk("t6_stray_memresp_rdy", memresp_rdy, 1'b1);
        chk("t6_stray_resp0_val", resp0_val, 1'b0);
        chk("t6_stray_resp1_val", resp1_val, 1'b0);
        p_rrdy = 100;
        step();

        // Random traffic with a mid-burst reset.
        quota = 1_000_000;
        for (int seg = 0; seg < 12; seg++) begin
            pv[0]   = $urandom_range(100);
            pv[1]   = $urandom_range(100);
            p_mrdy  = $urandom_range(100, 30);
            p_rrdy  = $urandom_range(100, 30);
            p_resp  = $urandom_range(80, 10);
            p_stray = $urandom_range(10);
            repeat (200) step();
            if (seg == 6) do_reset_mid();
        end
        drain();
        chk("final_q0_empty", exp_q0.size(), 0);
        chk("final_q1_empty", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
